// File: rtl/tri_bus_pkg.sv
// Shared types and defaults for the tristate bus sequencer.
package tri_bus_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    TURN   = 3'd4
  } state_t;

  localparam int NUM_REQ            = 2;
  localparam int DEF_DATA_WIDTH     = 2;
  localparam int DEF_SETUP_CYCLES   = 1;
  localparam int DEF_STROBE_CYCLES  = 2;
  localparam int DEF_HOLD_CYCLES    = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to rr_pri.
module rr_arbiter2
  import tri_bus_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               rr_pri,
  output logic [NUM_REQ-1:0] win
);

  // Tie-break only matters when both requesters are asserting.
  always_comb begin
    win = '0;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = rr_pri ? 2'b10 : 2'b01;
      default: win = '0;
    endcase
  end

endmodule

// File: rtl/tri_bus_sequencer.sv
// Arbitrates two requesters onto the tristate driver and times the
// setup / strobe / hold phases of we_n and ds_n for each transfer.
module tri_bus_sequencer
  import tri_bus_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
  parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    done,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] bus_data,
  output logic                  we_n,
  output logic                  ds_n
);

  localparam int MAX_A = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAX_P = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
  localparam int CW    = $clog2(MAX_P + 1);

  // Counter is loaded with length-1 on phase entry and the phase ends at zero.
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES - 1);

  state_t                state, nxt_state;
  logic [CW-1:0]         cnt, nxt_cnt;
  logic                  rr_pri, nxt_rr_pri;
  logic [NUM_REQ-1:0]    win;
  logic [NUM_REQ-1:0]    nxt_grant, nxt_done;
  logic                  nxt_busy, nxt_we_n, nxt_ds_n;
  logic [DATA_WIDTH-1:0] nxt_bus_data;

  rr_arbiter2 u_arb (
    .req    (req),
    .rr_pri (rr_pri),
    .win    (win)
  );

  // State, counter and all outputs are registered; reset parks the pins high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rr_pri   <= 1'b0;
      grant    <= '0;
      done     <= '0;
      busy     <= 1'b0;
      bus_data <= '0;
      we_n     <= 1'b1;
      ds_n     <= 1'b1;
    end else begin
      state    <= nxt_state;
      cnt      <= nxt_cnt;
      rr_pri   <= nxt_rr_pri;
      grant    <= nxt_grant;
      done     <= nxt_done;
      busy     <= nxt_busy;
      bus_data <= nxt_bus_data;
      we_n     <= nxt_we_n;
      ds_n     <= nxt_ds_n;
    end
  end

  // Phase sequencing; done is a single-cycle pulse so it defaults to zero.
  always_comb begin
    nxt_state    = state;
    nxt_cnt      = cnt;
    nxt_rr_pri   = rr_pri;
    nxt_grant    = grant;
    nxt_done     = '0;
    nxt_busy     = busy;
    nxt_bus_data = bus_data;
    nxt_we_n     = we_n;
    nxt_ds_n     = ds_n;
    case (state)
      IDLE: begin
        if (win != '0) begin
          nxt_state    = SETUP;
          nxt_cnt      = SETUP_LD;
          nxt_grant    = win;
          nxt_bus_data = win[1] ? wdata1 : wdata0;
          nxt_busy     = 1'b1;
          nxt_we_n     = 1'b0;
          nxt_ds_n     = 1'b1;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          nxt_state = STROBE;
          nxt_cnt   = STROBE_LD;
          nxt_ds_n  = 1'b0;
        end else begin
          nxt_cnt = cnt - 1'b1;
        end
      end
      STROBE: begin
        if (cnt == '0) begin
          nxt_state = HOLD;
          nxt_cnt   = HOLD_LD;
          nxt_ds_n  = 1'b1;
        end else begin
          nxt_cnt = cnt - 1'b1;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          nxt_state  = TURN;
          nxt_we_n   = 1'b1;
          nxt_done   = grant;
          nxt_grant  = '0;
          // Prefer whoever did not just own the bus.
          nxt_rr_pri = grant[0];
        end else begin
          nxt_cnt = cnt - 1'b1;
        end
      end
      TURN: begin
        // Dead cycle: req is ignored so the owner has time to drop it.
        nxt_state = IDLE;
        nxt_busy  = 1'b0;
      end
      default: nxt_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tri_bus_sequencer.sv
// Directed bench: default-parameter DUT plus a 3/1/2 phase-length DUT.
module tb_tri_bus_sequencer;
  import tri_bus_pkg::*;

  logic       clk, rst;
  logic [1:0] req, wdata0, wdata1;
  logic [1:0] grant, done, bus_data;
  logic       busy, we_n, ds_n;

  logic [1:0] req2, wdata0_2, wdata1_2;
  logic [1:0] grant2, done2, bus_data2;
  logic       busy2, we_n2, ds_n2;

  int tests = 0;
  int fails = 0;

  tri_bus_sequencer dut (
    .clk(clk), .rst(rst), .req(req), .wdata0(wdata0), .wdata1(wdata1),
    .grant(grant), .done(done), .busy(busy), .bus_data(bus_data),
    .we_n(we_n), .ds_n(ds_n)
  );

  tri_bus_sequencer #(
    .DATA_WIDTH(2), .SETUP_CYCLES(3), .STROBE_CYCLES(1), .HOLD_CYCLES(2)
  ) dut2 (
    .clk(clk), .rst(rst), .req(req2), .wdata0(wdata0_2), .wdata1(wdata1_2),
    .grant(grant2), .done(done2), .busy(busy2), .bus_data(bus_data2),
    .we_n(we_n2), .ds_n(ds_n2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(input string tag);
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s idle_timeout: busy=%b want 0 within 20 cycles", tag, busy);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; wdata0 = '0; wdata1 = '0;
    req2 = '0; wdata0_2 = '0; wdata1_2 = '0;
    #1;
    tests++;
    if ({grant, done, busy, bus_data, we_n, ds_n} !== 9'b00_00_0_00_11) begin
      fails++;
      $display("FAIL reset_outputs: got %b want 000000011",
               {grant, done, busy, bus_data, we_n, ds_n});
    end
    tests++;
    if ({grant2, done2, busy2, bus_data2, we_n2, ds_n2} !== 9'b00_00_0_00_11) begin
      fails++;
      $display("FAIL reset_outputs2: got %b want 000000011",
               {grant2, done2, busy2, bus_data2, we_n2, ds_n2});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (dut.state !== IDLE) begin
      fails++;
      $display("FAIL reset_state: got %0d want IDLE", dut.state);
    end
  endtask

  // One requester-0 transfer; req is dropped after cycle drop_cyc.
  task automatic test_single_xfer(input int drop_cyc, input string tag);
    // {grant, done, busy, we_n, ds_n}
    logic [6:0] exp [6] = '{7'b01_00_1_0_1, 7'b01_00_1_0_0, 7'b01_00_1_0_0,
                            7'b01_00_1_0_1, 7'b00_01_1_1_1, 7'b00_00_0_1_1};
    logic [6:0] obs;
    @(negedge clk);
    req = 2'b01; wdata0 = 2'b10; wdata1 = 2'b01;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      obs = {grant, done, busy, we_n, ds_n};
      tests++;
      if (obs !== exp[c-1]) begin
        fails++;
        $display("FAIL %s cyc%0d: got %b want %b", tag, c, obs, exp[c-1]);
      end
      if (c <= 4) begin
        tests++;
        if (bus_data !== 2'b10) begin
          fails++;
          $display("FAIL %s bus_data cyc%0d: got %b want 10", tag, c, bus_data);
        end
      end
      if (c == 1) wdata0 = 2'b01;
      if (c == drop_cyc) req = 2'b00;
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] exp_g, exp_d;
    do_reset();
    req = 2'b11; wdata0 = 2'b01; wdata1 = 2'b10;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      exp_g = (c <= 4 || c == 13) ? 2'b01 : (c >= 7 && c <= 10) ? 2'b10 : 2'b00;
      exp_d = (c == 5) ? 2'b01 : (c == 11) ? 2'b10 : 2'b00;
      tests++;
      if (grant !== exp_g || done !== exp_d) begin
        fails++;
        $display("FAIL simul cyc%0d: grant=%b done=%b want grant=%b done=%b",
                 c, grant, done, exp_g, exp_d);
      end
      if (c == 1 || c == 7 || c == 13) begin
        tests++;
        if (bus_data !== exp_g) begin
          fails++;
          $display("FAIL simul bus_data cyc%0d: got %b want %b", c, bus_data, exp_g);
        end
      end
    end
    req = 2'b00;
    wait_idle("simul");
  endtask

  task automatic test_late_request();
    logic [1:0] exp_g;
    @(negedge clk);
    req = 2'b01; wdata0 = 2'b01; wdata1 = 2'b10;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      exp_g = (c <= 4) ? 2'b01 : (c == 7) ? 2'b10 : 2'b00;
      tests++;
      if (grant !== exp_g || !$onehot0(grant)) begin
        fails++;
        $display("FAIL late cyc%0d: grant=%b want %b", c, grant, exp_g);
      end
      if (c == 2) begin
        tests++;
        if (ds_n !== 1'b0) begin
          fails++;
          $display("FAIL late strobe: ds_n=%b want 0", ds_n);
        end
        req = 2'b11;
      end
      if (c == 5) req = 2'b10;
    end
    tests++;
    if (bus_data !== 2'b10) begin
      fails++;
      $display("FAIL late bus_data: got %b want 10", bus_data);
    end
    req = 2'b00;
    wait_idle("late");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req = 2'b01; wdata0 = 2'b11;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (ds_n !== 1'b0) begin
      fails++;
      $display("FAIL rstmid strobe: ds_n=%b want 0", ds_n);
    end
    #2 rst = 1'b1; req = 2'b00;
    #1;
    tests++;
    if ({we_n, ds_n, grant, busy, done} !== 7'b11_00_0_00) begin
      fails++;
      $display("FAIL rstmid async: got %b want 1100000", {we_n, ds_n, grant, busy, done});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      tests++;
      if (done !== 2'b00 || busy !== 1'b0) begin
        fails++;
        $display("FAIL rstmid quiet cyc%0d: done=%b busy=%b want 00 0", c, done, busy);
      end
    end
    tests++;
    if (dut.state !== IDLE) begin
      fails++;
      $display("FAIL rstmid state: got %0d want IDLE", dut.state);
    end
    req = 2'b01;
    @(negedge clk);
    tests++;
    if (grant !== 2'b01) begin
      fails++;
      $display("FAIL rstmid regrant: grant=%b want 01", grant);
    end
    req = 2'b00;
    wait_idle("rstmid");
  endtask

  task automatic test_long_phases();
    logic [6:0] exp [8] = '{7'b01_00_1_0_1, 7'b01_00_1_0_1, 7'b01_00_1_0_1,
                            7'b01_00_1_0_0, 7'b01_00_1_0_1, 7'b01_00_1_0_1,
                            7'b00_01_1_1_1, 7'b00_00_0_1_1};
    logic [6:0] obs;
    @(negedge clk);
    req2 = 2'b01; wdata0_2 = 2'b11;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      obs = {grant2, done2, busy2, we_n2, ds_n2};
      tests++;
      if (obs !== exp[c-1]) begin
        fails++;
        $display("FAIL long cyc%0d: got %b want %b", c, obs, exp[c-1]);
      end
      if (c <= 6) begin
        tests++;
        if (bus_data2 !== 2'b11) begin
          fails++;
          $display("FAIL long bus_data cyc%0d: got %b want 11", c, bus_data2);
        end
      end
      if (c == 7) req2 = 2'b00;
    end
  endtask

  initial begin
    test_reset();
    test_single_xfer(5, "single");
    test_single_xfer(1, "drop");
    test_simultaneous();
    test_late_request();
    test_reset_mid();
    test_long_phases();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
